// File: rtl/memory_responder.sv
// Memory-side read responder: single outstanding read with fixed latency and a one-cycle
// valid pulse, plus an independent byte-strobed write port.
module memory_responder #(
  parameter int unsigned MEMDATAWIDTH = 32,
  parameter int unsigned MEMDEPTH     = 1024,
  parameter int unsigned READLATENCY  = 2,
  localparam int unsigned MD = (MEMDEPTH > 1) ? $clog2(MEMDEPTH) : 1,
  localparam int unsigned MW = MEMDATAWIDTH
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            mem_read_en_i,
  input  logic [MD-1:0]   mem_read_pos_i,
  output logic [MW-1:0]   mem_read_data_o,
  output logic            mem_read_valid_o,
  input  logic            mem_write_en_i,
  input  logic [MD-1:0]   mem_write_pos_i,
  input  logic [MW-1:0]   mem_write_data_i,
  input  logic [MW/8-1:0] mem_write_strb_i,
  output logic            busy_o
);

  localparam int unsigned CW = $clog2(READLATENCY + 1);
  localparam int unsigned NB = MW / 8;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWait    = 2'd1,
    StRespond = 2'd2
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [MW-1:0]   data_r_q;
  logic [MW-1:0]   data_q;
  logic            valid_q;
  logic            busy_q;

  logic [MW-1:0]   mem [MEMDEPTH];
  logic [MW-1:0]   rd_word;
  logic            rd_in_range;
  logic            wr_in_range;

  always_comb begin
    rd_in_range = 32'(mem_read_pos_i) < MEMDEPTH;
    wr_in_range = 32'(mem_write_pos_i) < MEMDEPTH;
    rd_word     = rd_in_range ? mem[mem_read_pos_i] : '0;
  end

  // Outputs are registered alongside the state so valid/data/busy line up with StRespond.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      data_r_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      data_q  <= '0;
      case (state_q)
        StIdle: begin
          if (mem_read_en_i) begin
            data_r_q <= rd_word;
            cnt_q    <= CW'(READLATENCY - 1);
            busy_q   <= 1'b1;
            if (READLATENCY == 1) begin
              state_q <= StRespond;
              valid_q <= 1'b1;
              data_q  <= rd_word;
            end else begin
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= StRespond;
            valid_q <= 1'b1;
            data_q  <= data_r_q;
          end
        end
        StRespond: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Array is never cleared; reads above sample it at the same edge, so they see the old word.
  always_ff @(posedge clk_i) begin
    if (rst_ni && mem_write_en_i && wr_in_range) begin
      for (int k = 0; k < NB; k++) begin
        if (mem_write_strb_i[k]) begin
          mem[mem_write_pos_i][8*k +: 8] <= mem_write_data_i[8*k +: 8];
        end
      end
    end
  end

  assign mem_read_data_o  = data_q;
  assign mem_read_valid_o = valid_q;
  assign busy_o           = busy_q;

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: directed scenarios plus a randomized run against a
// cycle-count reference model (accept time + latency, word array with byte merges).
module tb_memory_responder;

  localparam int unsigned MW    = 32;
  localparam int unsigned DEPTH = 1000;
  localparam int unsigned LAT   = 2;
  localparam int unsigned MD    = $clog2(DEPTH);

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          en = 1'b0;
  logic [MD-1:0] rpos = '0;
  logic [MW-1:0] rdata;
  logic          rvalid;
  logic          we = 1'b0;
  logic [MD-1:0] wpos = '0;
  logic [MW-1:0] wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [MW-1:0] model [DEPTH];

  memory_responder #(
    .MEMDATAWIDTH (MW),
    .MEMDEPTH     (DEPTH),
    .READLATENCY  (LAT)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .mem_read_en_i    (en),
    .mem_read_pos_i   (rpos),
    .mem_read_data_o  (rdata),
    .mem_read_valid_o (rvalid),
    .mem_write_en_i   (we),
    .mem_write_pos_i  (wpos),
    .mem_write_data_i (wdata),
    .mem_write_strb_i (wstrb),
    .busy_o           (busy)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [MW-1:0] merge(input logic [MW-1:0] old, input logic [MW-1:0] d,
                                          input logic [3:0] s);
    logic [MW-1:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (s[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  task automatic test_reset();
    rst_ni = 1'b0;
    tick();
    tick();
    n_tests++;
    if ({rvalid, busy, rdata} !== 34'h0) begin
      n_fail++;
      $display("FAIL reset got v=%b b=%b d=%h want all 0", rvalid, busy, rdata);
    end
    rst_ni = 1'b1;
  endtask

  task automatic test_fill();
    for (int a = 0; a < int'(DEPTH); a++) begin
      we = 1'b1; wpos = MD'(a); wdata = $urandom; wstrb = 4'hF;
      model[a] = wdata;
      tick();
    end
    we = 1'b0;
  endtask

  task automatic test_write_read();
    logic [33:0] exp;
    we = 1'b1; wpos = MD'(5); wdata = 32'hDEADBEEF; wstrb = 4'hF;
    model[5] = 32'hDEADBEEF;
    tick();
    we = 1'b0;
    for (int c = 0; c < 5; c++) begin
      exp = {1'(c == 2), 1'(c == 1 || c == 2), (c == 2) ? 32'hDEADBEEF : 32'h0};
      n_tests++;
      if ({rvalid, busy, rdata} !== exp) begin
        n_fail++;
        $display("FAIL t1_read c=%0d got %h want %h", c, {rvalid, busy, rdata}, exp);
      end
      en = (c == 0); rpos = MD'(5);
      tick();
    end
  endtask

  task automatic test_strobe();
    we = 1'b1; wpos = MD'(7); wdata = 32'h11223344; wstrb = 4'hF;
    tick();
    wdata = 32'hAABBCCDD; wstrb = 4'b0101;
    tick();
    we = 1'b0;
    model[7] = 32'h11BB33DD;
    en = 1'b1; rpos = MD'(7);
    tick();
    en = 1'b0;
    tick();
    n_tests++;
    if ({rvalid, rdata} !== {1'b1, 32'h11BB33DD}) begin
      n_fail++;
      $display("FAIL t2_strobe got v=%b d=%h want v=1 d=11bb33dd", rvalid, rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [33:0] exp;
    logic        v;
    for (int c = 0; c < 8; c++) begin
      v   = (c == 2 || c == 5);
      exp = {v, 1'(c == 1 || c == 2 || c == 4 || c == 5), v ? model[3] : 32'h0};
      n_tests++;
      if ({rvalid, busy, rdata} !== exp) begin
        n_fail++;
        $display("FAIL t3_b2b c=%0d got %h want %h", c, {rvalid, busy, rdata}, exp);
      end
      en = (c < 6); rpos = MD'(3);
      tick();
    end
  endtask

  task automatic test_rw_same_cycle();
    we = 1'b1; wpos = MD'(9); wdata = 32'h1; wstrb = 4'hF;
    tick();
    en = 1'b1; rpos = MD'(9); wdata = 32'h2;
    tick();
    en = 1'b0; we = 1'b0;
    model[9] = 32'h2;
    tick();
    n_tests++;
    if ({rvalid, rdata} !== {1'b1, 32'h1}) begin
      n_fail++;
      $display("FAIL t4_old got v=%b d=%h want v=1 d=00000001", rvalid, rdata);
    end
    tick();
    en = 1'b1;
    tick();
    en = 1'b0;
    tick();
    n_tests++;
    if ({rvalid, rdata} !== {1'b1, 32'h2}) begin
      n_fail++;
      $display("FAIL t4_new got v=%b d=%h want v=1 d=00000002", rvalid, rdata);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    logic [33:0] exp;
    for (int c = 0; c < 10; c++) begin
      exp = {1'b0, 1'(c == 1), 32'h0};
      n_tests++;
      if ({rvalid, busy, rdata} !== exp) begin
        n_fail++;
        $display("FAIL t5_abort c=%0d got %h want %h", c, {rvalid, busy, rdata}, exp);
      end
      en = (c == 0); rpos = MD'(9);
      rst_ni = !(c >= 1 && c <= 3);
      we = (c == 2); wpos = MD'(9); wdata = 32'h55; wstrb = 4'hF;
      tick();
    end
    we = 1'b0; rst_ni = 1'b1;
    en = 1'b1; rpos = MD'(9);
    tick();
    en = 1'b0;
    tick();
    n_tests++;
    if ({rvalid, rdata} !== {1'b1, model[9]}) begin
      n_fail++;
      $display("FAIL t5_retain got v=%b d=%h want v=1 d=%h", rvalid, rdata, model[9]);
    end
    tick();
  endtask

  task automatic test_out_of_range();
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        we = 1'b1; wpos = MD'(1020); wdata = 32'hFFFFFFFF; wstrb = 4'hF;
        tick();
        we = 1'b0;
      end
      en = 1'b1; rpos = MD'(1020);
      tick();
      en = 1'b0;
      tick();
      n_tests++;
      if ({rvalid, busy, rdata} !== {2'b11, 32'h0}) begin
        n_fail++;
        $display("FAIL t6_oor pass=%0d got v=%b b=%b d=%h want v=1 b=1 d=0", pass, rvalid, busy,
                 rdata);
      end
      tick();
    end
  endtask

  task automatic test_random(input int n);
    int            acc;
    logic [MW-1:0] snap;
    logic          ev, eb;
    logic [33:0]   exp;
    acc  = -100;
    snap = '0;
    for (int cyc = 0; cyc < n; cyc++) begin
      ev  = (acc >= 0) && (cyc == acc + int'(LAT));
      eb  = (acc >= 0) && (cyc > acc) && (cyc <= acc + int'(LAT));
      exp = {ev, eb, ev ? snap : 32'h0};
      n_tests++;
      if ({rvalid, busy, rdata} !== exp) begin
        n_fail++;
        $display("FAIL rand cyc=%0d got %h want %h", cyc, {rvalid, busy, rdata}, exp);
      end
      en    = 1'($urandom_range(0, 1));
      rpos  = ($urandom_range(0, 7) == 0) ? MD'($urandom_range(DEPTH, 1023))
            : MD'($urandom_range(0, 15));
      we    = 1'($urandom_range(0, 1));
      wpos  = ($urandom_range(0, 7) == 0) ? MD'($urandom_range(DEPTH, 1023))
            : MD'($urandom_range(0, 15));
      wdata = $urandom;
      wstrb = 4'($urandom_range(0, 15));
      if (en && !eb) begin
        snap = (int'(rpos) < int'(DEPTH)) ? model[rpos] : 32'h0;
        acc  = cyc;
      end
      if (we && int'(wpos) < int'(DEPTH)) model[wpos] = merge(model[wpos], wdata, wstrb);
      tick();
    end
    en = 1'b0; we = 1'b0;
    tick();
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_write_read();
    test_strobe();
    test_back_to_back();
    test_rw_same_cycle();
    test_reset_abort();
    test_out_of_range();
    test_random(600);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
